// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the FMUL32 datapath: operand classes, special-result
// encodings and exponent constants.
package fp32_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORMAL = 3'd2,
        CLS_INF    = 3'd3,
        CLS_QNAN   = 3'd4,
        CLS_SNAN   = 3'd5
    } fp_class_e;

    typedef enum logic [1:0] {
        EC_NONE = 2'b00,
        EC_ZERO = 2'b01,
        EC_INF  = 2'b10,
        EC_NAN  = 2'b11
    } exp_cond_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    function automatic fp_class_e fp_classify(fp32_t x);
        if (x.exp == 8'hFF) begin
            if (x.frac == '0) return CLS_INF;
            return x.frac[22] ? CLS_QNAN : CLS_SNAN;
        end
        if (x.exp == 8'h00) return (x.frac == '0) ? CLS_ZERO : CLS_DENORM;
        return CLS_NORMAL;
    endfunction

    function automatic logic is_nan(fp_class_e c);
        return (c == CLS_QNAN) || (c == CLS_SNAN);
    endfunction

    // inf x zero is an invalid product, so it folds into the NaN result.
    function automatic exp_cond_e fp_exp_cond(fp_class_e ca, fp_class_e cb);
        if (is_nan(ca) || is_nan(cb) ||
            (ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF))
            return EC_NAN;
        if (ca == CLS_INF || cb == CLS_INF) return EC_INF;
        if (ca == CLS_ZERO || cb == CLS_ZERO) return EC_ZERO;
        return EC_NONE;
    endfunction

    typedef struct packed {
        fp32_t      a;
        fp32_t      b;
        fp_class_e  a_cls;
        fp_class_e  b_cls;
        exp_cond_e  cond;
        logic [4:0] a_lzc;
        logic [4:0] b_lzc;
    } s1_t;

endpackage

// File: rtl/fp32_unpack_prenorm_if.sv
// Operand-pair input handshake and unpacked-result output handshake of the FP32 unpack stage.
interface fp32_unpack_prenorm_if #(parameter int EXP_OUT_W = 10);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          a;
    logic [31:0]          b;
    logic                 out_valid;
    logic                 out_ready;
    logic                 a_sign;
    logic                 b_sign;
    logic [EXP_OUT_W-1:0] a_exp;
    logic [EXP_OUT_W-1:0] b_exp;
    logic [23:0]          a_mant;
    logic [23:0]          b_mant;
    logic [2:0]           a_class;
    logic [2:0]           b_class;
    logic                 res_sign;
    logic [1:0]           exp_condition;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, a_sign, b_sign, a_exp, b_exp,
               a_mant, b_mant, a_class, b_class, res_sign, exp_condition
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, a_sign, b_sign, a_exp, b_exp,
               a_mant, b_mant, a_class, b_class, res_sign, exp_condition
    );
endinterface

// File: rtl/leading_zero_counter.sv
// Counts leading zeros of a DATA_W-bit word; an all-zero word yields DATA_W.
module leading_zero_counter #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  cnt
);
    logic found;

    always_comb begin
        cnt   = CNT_W'(DATA_W);
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found && data[i]) begin
                cnt   = CNT_W'(DATA_W - 1 - i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp32_unpack_prenorm.sv
// Two-stage FP32 operand unpacker: classifies both operands, then left-justifies
// denormal mantissas so the multiplier always sees a hidden bit at bit 23.
module fp32_unpack_prenorm
    import fp32_pkg::*;
#(
    parameter int EXP_OUT_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    fp32_unpack_prenorm_if.slave  bus
);
    typedef struct packed {
        logic                 sign;
        logic [EXP_OUT_W-1:0] exp;
        logic [23:0]          mant;
        fp_class_e            cls;
    } op_out_t;

    typedef struct packed {
        op_out_t   a;
        op_out_t   b;
        logic      res_sign;
        exp_cond_e cond;
    } s2_t;

    // Denormal exponent is 1 - lzc, carried as two's complement in EXP_OUT_W bits.
    function automatic op_out_t prenorm(fp32_t x, fp_class_e c, logic [4:0] lzc);
        op_out_t o;
        o      = '0;
        o.sign = x.sign;
        o.cls  = c;
        case (c)
            CLS_NORMAL: begin
                o.exp  = EXP_OUT_W'(x.exp);
                o.mant = {1'b1, x.frac};
            end
            CLS_DENORM: begin
                o.exp  = EXP_OUT_W'(1) - EXP_OUT_W'(lzc);
                o.mant = {1'b0, x.frac} << lzc;
            end
            CLS_INF:  o.exp = EXP_OUT_W'(EXP_MAX);
            CLS_QNAN, CLS_SNAN: begin
                o.exp  = EXP_OUT_W'(EXP_MAX);
                o.mant = {1'b0, x.frac};
            end
            default: ;
        endcase
        return o;
    endfunction

    fp32_t      in_a, in_b;
    logic [4:0] a_lzc, b_lzc;
    logic       s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
    s1_t        s1_q, s1_d;
    s2_t        s2_q, s2_d;
    logic       s1_adv, in_ready, accept;

    assign in_a = fp32_t'(bus.a);
    assign in_b = fp32_t'(bus.b);

    leading_zero_counter #(.DATA_W(24)) u_lzc_a (.data({1'b0, in_a.frac}), .cnt(a_lzc));
    leading_zero_counter #(.DATA_W(24)) u_lzc_b (.data({1'b0, in_b.frac}), .cnt(b_lzc));

    assign s1_adv   = s1_valid_q && (!out_valid_q || bus.out_ready);
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d.a     = in_a;
            s1_d.b     = in_b;
            s1_d.a_cls = fp_classify(in_a);
            s1_d.b_cls = fp_classify(in_b);
            s1_d.cond  = fp_exp_cond(s1_d.a_cls, s1_d.b_cls);
            s1_d.a_lzc = a_lzc;
            s1_d.b_lzc = b_lzc;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_d        = s2_q;
        out_valid_d = out_valid_q;
        if (s1_adv) begin
            out_valid_d   = 1'b1;
            s2_d.a        = prenorm(s1_q.a, s1_q.a_cls, s1_q.a_lzc);
            s2_d.b        = prenorm(s1_q.b, s1_q.b_cls, s1_q.b_lzc);
            s2_d.res_sign = s1_q.a.sign ^ s1_q.b.sign;
            s2_d.cond     = s1_q.cond;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.a_sign        = s2_q.a.sign;
    assign bus.b_sign        = s2_q.b.sign;
    assign bus.a_exp         = s2_q.a.exp;
    assign bus.b_exp         = s2_q.b.exp;
    assign bus.a_mant        = s2_q.a.mant;
    assign bus.b_mant        = s2_q.b.mant;
    assign bus.a_class       = s2_q.a.cls;
    assign bus.b_class       = s2_q.b.cls;
    assign bus.res_sign      = s2_q.res_sign;
    assign bus.exp_condition = s2_q.cond;
endmodule

// File: tb/tb_fp32_unpack_prenorm.sv
// Randomized scoreboard bench for fp32_unpack_prenorm with directed corner pairs,
// backpressure and asynchronous reset scenarios.
module tb_fp32_unpack_prenorm;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fp32_unpack_prenorm_if #(.EXP_OUT_W(10)) bus();
    fp32_unpack_prenorm #(.EXP_OUT_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int n_acc = 0, n_out = 0, n_drop = 0;
    logic [78:0] exp_q[$];
    logic [78:0] dut_w, held, last_out;
    logic        held_vld = 1'b0, last_ov = 1'b0, last_acc = 1'b0;

    // {a: sign,exp,mant,cls | b: sign,exp,mant,cls | res_sign | cond}
    assign dut_w = {bus.a_sign, bus.a_exp, bus.a_mant, bus.a_class,
                    bus.b_sign, bus.b_exp, bus.b_mant, bus.b_class,
                    bus.res_sign, bus.exp_condition};

    task automatic chk(string tag, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: value-level decode of one binary32 operand.
    function automatic logic [37:0] ref_op(logic [31:0] x);
        int          e;
        logic [23:0] m;
        logic [2:0]  c;
        logic [9:0]  ex;
        m = '0;
        e = 0;
        if (x[30:23] == 8'hFF) begin
            e = 255;
            if (x[22:0] == 23'd0) c = 3'd3;
            else begin
                m = {1'b0, x[22:0]};
                c = x[22] ? 3'd4 : 3'd5;
            end
        end else if (x[30:23] == 8'h00) begin
            if (x[22:0] == 23'd0) c = 3'd0;
            else begin
                c = 3'd1;
                m = {1'b0, x[22:0]};
                e = 1;
                while (m < 24'h800000) begin
                    m = m * 2;
                    e = e - 1;
                end
            end
        end else begin
            c = 3'd2;
            e = int'(x[30:23]);
            m = 24'h800000 + {1'b0, x[22:0]};
        end
        ex = e[9:0];
        return {x[31], ex, m, c};
    endfunction

    function automatic logic [78:0] ref_pair(logic [31:0] a, logic [31:0] b);
        logic [37:0] ra, rb;
        logic [2:0]  ca, cb;
        logic [1:0]  cond;
        ra = ref_op(a);
        rb = ref_op(b);
        ca = ra[2:0];
        cb = rb[2:0];
        if (ca >= 3'd4 || cb >= 3'd4 || (ca == 3'd3 && cb == 3'd0) || (ca == 3'd0 && cb == 3'd3))
            cond = 2'b11;
        else if (ca == 3'd3 || cb == 3'd3) cond = 2'b10;
        else if (ca == 3'd0 || cb == 3'd0) cond = 2'b01;
        else cond = 2'b00;
        return {ra, rb, a[31] ^ b[31], cond};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0, 1:    rnd_op = r;
            2:       rnd_op = {r[31], 8'h00, r[22:0]};
            3:       rnd_op = {r[31], 31'd0};
            4:       rnd_op = {r[31], 8'hFF, (r[0] ? 23'd0 : (r[22:0] | 23'd1))};
            default: rnd_op = {r[31], 8'h00, 23'd1 << (r[4:0] % 5'd23)};
        endcase
    endfunction

    // Sample on the falling edge, then advance past the next rising edge.
    task automatic step();
        @(negedge clk);
        last_ov  = bus.out_valid;
        last_out = dut_w;
        last_acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid) begin
            if (held_vld) chk("hold_stable", dut_w, held);
            if (bus.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1'b1, 1'b0);
                else chk("data", dut_w, exp_q.pop_front());
                n_out++;
                held_vld = 1'b0;
            end else begin
                held     = dut_w;
                held_vld = 1'b1;
            end
        end else begin
            held_vld = 1'b0;
        end
        if (last_acc) begin
            exp_q.push_back(ref_pair(bus.a, bus.b));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    // Single pair into an empty pipeline; out_valid must show up two edges after presentation.
    task automatic send(logic [31:0] a, logic [31:0] b);
        int lat;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!last_ov && lat < 8);
        chk("latency", lat, 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, base;
        logic [31:0] bp_a[4], bp_b[4];
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_data", dut_w, 79'd0);
        #4 rst = 1'b0;
        @(posedge clk);
        #1;

        send(32'h3F800000, 32'h40000000);
        chk("r42_a_exp", last_out[77:68], 10'd127);
        chk("r42_a_mant", last_out[67:44], 24'h800000);
        chk("r42_b_exp", last_out[39:30], 10'd128);
        chk("r42_cls", {last_out[43:41], last_out[5:3]}, {3'd2, 3'd2});
        chk("r42_cond", last_out[1:0], 2'b00);

        send(32'h00000001, 32'h00400000);
        chk("r43_a_exp", last_out[77:68], 10'h3EA);
        chk("r43_a_mant", last_out[67:44], 24'h800000);
        chk("r43_a_cls", last_out[43:41], 3'd1);
        chk("r43_b_exp", last_out[39:30], 10'd0);
        chk("r43_b_mant", last_out[29:6], 24'h800000);

        send(32'h7F800000, 32'h00000000);
        chk("inf_x_zero_cond", last_out[1:0], 2'b11);
        send(32'hFF800000, 32'h3F800000);
        chk("ninf_cond", last_out[1:0], 2'b10);
        chk("ninf_res_sign", last_out[2], 1'b1);
        send(32'h7FC00000, 32'h3F800000);
        chk("qnan_cls", last_out[43:41], 3'd4);
        send(32'h7F800001, 32'h3F800000);
        chk("snan_cls", last_out[43:41], 3'd5);
        chk("snan_cond", last_out[1:0], 2'b11);

        // Backpressure: four pairs against a stalled consumer.
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = rnd_op();
            bp_b[i] = rnd_op();
        end
        base = n_out;
        idx = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.a = bp_a[idx];
            bus.b = bp_b[idx];
            step();
            if (last_acc) idx++;
        end
        chk("bp_accepts_stalled", idx, 2);
        chk("bp_in_ready_low", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            bus.a = bp_a[idx];
            bus.b = bp_b[idx];
            step();
            if (last_acc) idx++;
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) step();
        chk("bp_delivered", n_out - base, 4);

        // Asynchronous reset between edges with two pairs in flight.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = rnd_op(); bus.b = rnd_op();
        step();
        bus.a = rnd_op(); bus.b = rnd_op();
        step();
        bus.in_valid = 1'b0;
        chk("pre_arst_in_flight", exp_q.size(), 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_in_ready", bus.in_ready, 1'b1);
        chk("arst_data", dut_w, 79'd0);
        n_drop += exp_q.size();
        exp_q.delete();
        held_vld = 1'b0;
        step();
        #2 rst = 1'b0;
        bus.out_ready = 1'b1;
        base = n_out;
        repeat (3) step();
        chk("post_rst_no_stale", n_out - base, 0);
        send(rnd_op(), rnd_op());

        // Random traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.a = rnd_op();
            bus.b = rnd_op();
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) step();
        chk("drain_empty", exp_q.size(), 0);
        chk("accept_vs_delivered", n_out + n_drop, n_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
